// File: rtl/gsim_band_matvec.sv
// Banded Toeplitz forward model b = A*x (16x16, taps 20/-13/6/-1) over a Q16.16 x stream.
// A 7-deep window of x is combined with shift-and-add only; b is rounded and saturated to int16.
module gsim_band_matvec #(
  parameter int N     = 16,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [31:0] x_in,
  output logic        out_valid,
  output logic [15:0] b_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  localparam logic [4:0] LAST_LD  = 5'(N - 1);
  localparam logic [4:0] LAST_FL  = 5'(N + 3);
  localparam logic [4:0] FIRST_EM = 5'd4;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(32'h0000_8000);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32'h0000_7FFF);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  state_t            state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [6:0][31:0]  win_q, win_d;
  logic              ov_q, ov_d;
  logic [15:0]       b_q, b_d;

  function automatic logic signed [ACC_W-1:0] sx(input logic [31:0] v);
    return {{(ACC_W-32){v[31]}}, v};
  endfunction

  // win_q[0] is the newest sample; win_q[3] is the centre tap of the row being emitted.
  logic signed [ACC_W-1:0] c, s1, s2, s3, acc, rnd;
  logic [15:0]             bsat;

  always_comb begin
    c    = sx(win_q[3]);
    s1   = sx(win_q[2]) + sx(win_q[4]);
    s2   = sx(win_q[1]) + sx(win_q[5]);
    s3   = sx(win_q[0]) + sx(win_q[6]);
    acc  = (c <<< 4) + (c <<< 2)
         - ((s1 <<< 3) + (s1 <<< 2) + s1)
         + (s2 <<< 2) + (s2 <<< 1)
         - s3;
    rnd  = (acc + HALF) >>> 16;
    if (rnd > MAXV)      bsat = 16'h7FFF;
    else if (rnd < MINV) bsat = 16'h8000;
    else                 bsat = rnd[15:0];
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    win_d   = win_q;
    ov_d    = ov_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        ov_d = 1'b0;
        if (in_en) begin
          win_d    = '0;
          win_d[0] = x_in;
          count_d  = 5'd1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (in_en) begin
          win_d   = {win_q[5:0], x_in};
          count_d = count_q + 5'd1;
          ov_d    = (count_q >= FIRST_EM);
          if (count_q >= FIRST_EM) b_d = bsat;
          if (count_q == LAST_LD) state_d = FLUSH;
        end else begin
          // Aborted frame: drop the partial window, keep the last emitted b_out.
          state_d = IDLE;
          ov_d    = 1'b0;
          win_d   = '0;
          count_d = '0;
        end
      end
      FLUSH: begin
        win_d = {win_q[5:0], 32'h0};
        ov_d  = 1'b1;
        b_d   = bsat;
        if (count_q == LAST_FL) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      win_q   <= '0;
      ov_q    <= 1'b0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      win_q   <= win_d;
      ov_q    <= ov_d;
      b_q     <= b_d;
    end
  end

  assign out_valid = ov_q;
  assign b_out     = b_q;
  assign busy      = (state_q != IDLE);

endmodule
